// File: rtl/dma_host_pkg.sv
// Shared types and DMA register offsets for the 8237A host programming engine.
package dma_host_pkg;

    typedef enum logic [1:0] {
        OpWrite8  = 2'd0,
        OpRead8   = 2'd1,
        OpWrite16 = 2'd2,
        OpRead16  = 2'd3
    } op_e;

    // Request-level states; the bus engine's states cover SETUP/STROBE/HOLD.
    typedef enum logic [1:0] {CtlIdle, CtlWaitBus, CtlBus, CtlResp} ctl_state_e;
    typedef enum logic [1:0] {BusIdle, BusSetup, BusStrobe, BusHold} bus_state_e;
    typedef enum logic [1:0] {PhClr, PhLo, PhHi} phase_e;

    localparam logic [3:0] AddrCmdStat    = 4'h8;
    localparam logic [3:0] AddrRequest    = 4'h9;
    localparam logic [3:0] AddrSingleMask = 4'hA;
    localparam logic [3:0] AddrMode       = 4'hB;
    localparam logic [3:0] AddrClrFf      = 4'hC;
    localparam logic [3:0] AddrMasterClr  = 4'hD;
    localparam logic [3:0] AddrClrMask    = 4'hE;
    localparam logic [3:0] AddrAllMask    = 4'hF;

    function automatic logic [3:0] ch_addr_reg(input logic [1:0] ch);
        return {1'b0, ch, 1'b0};
    endfunction

    function automatic logic [3:0] ch_count_reg(input logic [1:0] ch);
        return {1'b0, ch, 1'b1};
    endfunction

    function automatic logic op_is_write(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_wide(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/dma_bus_cycle.sv
// One CPU-interface bus cycle (SETUP, STROBE, HOLD) on the DMA slave port.
module dma_bus_cycle
    import dma_host_pkg::*;
#(
    parameter int unsigned SetupCyc  = 1,
    parameter int unsigned StrobeCyc = 2,
    parameter int unsigned HoldCyc   = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       is_write_i,
    input  logic [3:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       cs_n_o,
    output logic       ior_n_o,
    output logic       iow_n_o,
    output logic [3:0] a_o,
    output logic [7:0] db_out_o,
    output logic       db_oe_o,
    input  logic [7:0] db_in_i
);

    localparam logic [3:0] SetupLd  = 4'(SetupCyc - 1);
    localparam logic [3:0] StrobeLd = 4'(StrobeCyc - 1);
    localparam logic [3:0] HoldLd   = 4'(HoldCyc - 1);

    bus_state_e st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       active;

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_o  = 1'b0;
        unique case (st_q)
            BusIdle: ;
            BusSetup: begin
                if (cnt_q == 4'd0) begin
                    st_d  = BusStrobe;
                    cnt_d = StrobeLd;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BusStrobe: begin
                if (cnt_q == 4'd0) begin
                    st_d  = BusHold;
                    cnt_d = HoldLd;
                    if (!wr_q) rdata_d = db_in_i;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BusHold: begin
                if (cnt_q == 4'd0) begin
                    done_o = 1'b1;
                    st_d   = BusIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: st_d = BusIdle;
        endcase
        // A start may overlap the final HOLD cycle of the previous bus cycle.
        if (start_i) begin
            st_d    = BusSetup;
            cnt_d   = SetupLd;
            wr_d    = is_write_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q    <= BusIdle;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 4'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign active   = (st_q != BusIdle);
    assign cs_n_o   = ~active;
    assign ior_n_o  = ~((st_q == BusStrobe) && !wr_q);
    assign iow_n_o  = ~((st_q == BusStrobe) && wr_q);
    assign a_o      = active ? addr_q : 4'd0;
    assign db_oe_o  = active && wr_q;
    assign db_out_o = db_oe_o ? wdata_q : 8'd0;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/dma_host_prog.sv
// Host programming engine for an 8237A DMA: request latching, byte-pair phasing, HLDA gating.
// DMA_HOST_AUTO_CLR_FF_EN: prefix every 16-bit op with a clear-byte-pointer write.
module dma_host_prog
    import dma_host_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [3:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    input  logic        HLDA,
    output logic        CS_N,
    output logic        IOR_N,
    output logic        IOW_N,
    output logic [3:0]  A,
    output logic [7:0]  DB_OUT,
    output logic        DB_OE,
    input  logic [7:0]  DB_IN
);

    ctl_state_e  ctl_q, ctl_d;
    op_e         op_q, op_d;
    phase_e      phase_q, phase_d;
    logic [3:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] rsp_q, rsp_d;

    op_e         iss_op;
    phase_e      iss_phase;
    logic [3:0]  iss_addr_base;
    logic [15:0] iss_wdata;
    logic        bus_start, bus_wr, bus_done;
    logic [3:0]  bus_addr;
    logic [7:0]  bus_wbyte, bus_rdata;

    function automatic phase_e first_phase(input op_e op);
`ifdef DMA_HOST_AUTO_CLR_FF_EN
        return op_is_wide(op) ? PhClr : PhLo;
`else
        return PhLo;
`endif
    endfunction

    always_comb begin
        ctl_d         = ctl_q;
        op_d          = op_q;
        phase_d       = phase_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        lo_d          = lo_q;
        rsp_d         = rsp_q;
        bus_start     = 1'b0;
        iss_op        = op_q;
        iss_phase     = phase_q;
        iss_addr_base = addr_q;
        iss_wdata     = wdata_q;
        unique case (ctl_q)
            CtlIdle: begin
                if (req_valid) begin
                    iss_op        = op_e'(req_op);
                    iss_addr_base = req_addr;
                    iss_wdata     = req_wdata;
                    iss_phase     = first_phase(op_e'(req_op));
                    op_d          = op_e'(req_op);
                    addr_d        = req_addr;
                    wdata_d       = req_wdata;
                    phase_d       = iss_phase;
                    bus_start     = !HLDA;
                    ctl_d         = HLDA ? CtlWaitBus : CtlBus;
                end
            end
            CtlWaitBus: begin
                if (!HLDA) begin
                    bus_start = 1'b1;
                    ctl_d     = CtlBus;
                end
            end
            CtlBus: begin
                if (bus_done) begin
                    if (phase_q == PhLo) lo_d = bus_rdata;
                    if (op_is_wide(op_q) && phase_q != PhHi) begin
                        iss_phase = (phase_q == PhClr) ? PhLo : PhHi;
                        phase_d   = iss_phase;
                        bus_start = !HLDA;
                        ctl_d     = HLDA ? CtlWaitBus : CtlBus;
                    end else begin
                        ctl_d = CtlResp;
                        unique case (op_q)
                            OpRead8:  rsp_d = {8'h00, bus_rdata};
                            OpRead16: rsp_d = {bus_rdata, lo_q};
                            default:  rsp_d = 16'h0000;
                        endcase
                    end
                end
            end
            CtlResp: ctl_d = CtlIdle;
            default: ctl_d = CtlIdle;
        endcase
    end

    // The clear-byte-pointer cycle is always a write of 8'h00, whatever the op.
    assign bus_wr    = (iss_phase == PhClr) || op_is_write(iss_op);
    assign bus_addr  = (iss_phase == PhClr) ? AddrClrFf : iss_addr_base;
    assign bus_wbyte = (iss_phase == PhClr) ? 8'h00 :
                       (iss_phase == PhHi)  ? iss_wdata[15:8] : iss_wdata[7:0];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctl_q   <= CtlIdle;
            op_q    <= OpWrite8;
            phase_q <= PhLo;
            addr_q  <= 4'd0;
            wdata_q <= 16'd0;
            lo_q    <= 8'd0;
            rsp_q   <= 16'd0;
        end else begin
            ctl_q   <= ctl_d;
            op_q    <= op_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rsp_q   <= rsp_d;
        end
    end

    assign req_ready = (ctl_q == CtlIdle);
    assign rsp_valid = (ctl_q == CtlResp);
    assign rsp_rdata = rsp_q;

    dma_bus_cycle #(
        .SetupCyc  (SETUP_CYC),
        .StrobeCyc (STROBE_CYC),
        .HoldCyc   (HOLD_CYC)
    ) u_bus (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .start_i    (bus_start),
        .is_write_i (bus_wr),
        .addr_i     (bus_addr),
        .wdata_i    (bus_wbyte),
        .done_o     (bus_done),
        .rdata_o    (bus_rdata),
        .cs_n_o     (CS_N),
        .ior_n_o    (IOR_N),
        .iow_n_o    (IOW_N),
        .a_o        (A),
        .db_out_o   (DB_OUT),
        .db_oe_o    (DB_OE),
        .db_in_i    (DB_IN)
    );

endmodule

// File: tb/tb_dma_host_prog.sv
// Self-checking bench for dma_host_prog: directed table, randomized ops with HLDA, reset and
// back-to-back sequences. Honours DMA_HOST_AUTO_CLR_FF_EN for the 16-bit plan.
module tb_dma_host_prog;

    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;
    localparam int B = S + T + H;
`ifdef DMA_HOST_AUTO_CLR_FF_EN
    localparam int K16 = 3;
`else
    localparam int K16 = 2;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [3:0]  req_addr = 4'd0;
    logic [15:0] req_wdata = 16'd0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        HLDA = 1'b0;
    logic        CS_N, IOR_N, IOW_N, DB_OE;
    logic [3:0]  A;
    logic [7:0]  DB_OUT;
    logic [7:0]  DB_IN = 8'd0;

    int checks = 0;
    int errors = 0;

    dma_host_prog #(
        .SETUP_CYC  (S),
        .STROBE_CYC (T),
        .HOLD_CYC   (H)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .HLDA      (HLDA),
        .CS_N      (CS_N),
        .IOR_N     (IOR_N),
        .IOW_N     (IOW_N),
        .A         (A),
        .DB_OUT    (DB_OUT),
        .DB_OE     (DB_OE),
        .DB_IN     (DB_IN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: list the bus cycles an op needs, place them in time with the HLDA stalls,
    // then compare every pin every cycle. Called #1 after a rising edge with the DUT idle.
    task automatic run_req(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] wd,
                           input int h0, input int h1, input int h2,
                           input logic [7:0] din_lo, input logic [7:0] din_hi,
                           input bit rand_hlda, output int rsp_cyc, output logic [15:0] rsp_dat);
        logic [3:0]  pa[3];
        bit          pw[3];
        logic [7:0]  pb[3];
        int          hh[3];
        int          busidx[64];
        int          off[64];
        bit          hl[64];
        bit          hl_free[64];
        int          n, t, st, exp_rsp;
        bit          wide, wr;
        logic [15:0] exp_rd;
        logic [16:0] act_v, exp_v;
        hh[0] = h0; hh[1] = h1; hh[2] = h2;
        wide = op[1];
        wr = !op[0];
        n = 0;
        if (wide) begin
`ifdef DMA_HOST_AUTO_CLR_FF_EN
            pa[n] = 4'hC; pw[n] = 1'b1; pb[n] = 8'h00; n++;
`endif
            pa[n] = addr; pw[n] = wr; pb[n] = wr ? wd[7:0] : din_lo; n++;
            pa[n] = addr; pw[n] = wr; pb[n] = wr ? wd[15:8] : din_hi; n++;
            exp_rd = wr ? 16'h0000 : {din_hi, din_lo};
        end else begin
            pa[0] = addr; pw[0] = wr; pb[0] = wr ? wd[7:0] : din_lo; n = 1;
            exp_rd = wr ? 16'h0000 : {8'h00, din_lo};
        end
        for (int c = 0; c < 64; c++) begin
            busidx[c] = -1; off[c] = 0; hl[c] = 1'b0; hl_free[c] = 1'b1;
        end
        t = 0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < hh[i]; k++) begin
                hl[t + k] = 1'b1;
                hl_free[t + k] = 1'b0;
            end
            hl_free[t + hh[i]] = 1'b0;
            st = t + hh[i] + 1;
            for (int k = 0; k < B; k++) begin
                busidx[st + k] = i;
                off[st + k] = k;
            end
            t = st + B - 1;
        end
        exp_rsp = t + 1;
        rsp_cyc = -1;
        rsp_dat = 16'h0;
        req_op = op; req_addr = addr; req_wdata = wd;
        for (int c = 0; c <= exp_rsp + 2; c++) begin
            req_valid = (c == 0);
            HLDA = (rand_hlda && hl_free[c]) ? 1'($urandom) : hl[c];
            if (busidx[c] >= 0 && !pw[busidx[c]] && off[c] == S + T - 1)
                DB_IN = pb[busidx[c]];
            else
                DB_IN = 8'($urandom);
            @(negedge CLK);
            if (busidx[c] >= 0) begin
                exp_v = {(c == 0 || c > exp_rsp), (c == exp_rsp), 1'b0,
                         !(off[c] >= S && off[c] < S + T && !pw[busidx[c]]),
                         !(off[c] >= S && off[c] < S + T && pw[busidx[c]]),
                         pa[busidx[c]], pw[busidx[c]], pw[busidx[c]] ? pb[busidx[c]] : 8'h00};
                act_v = {req_ready, rsp_valid, CS_N, IOR_N, IOW_N, A, DB_OE,
                         DB_OE ? DB_OUT : 8'h00};
            end else begin
                exp_v = {(c == 0 || c > exp_rsp), (c == exp_rsp), 3'b111, 4'h0, 1'b0, 8'h00};
                act_v = {req_ready, rsp_valid, CS_N, IOR_N, IOW_N, CS_N ? 4'h0 : A, DB_OE,
                         DB_OE ? DB_OUT : 8'h00};
            end
            chk($sformatf("pins op%0d c%0d", op, c), 32'(act_v), 32'(exp_v));
            if (rsp_valid && rsp_cyc < 0) begin
                rsp_cyc = c;
                rsp_dat = rsp_rdata;
            end
            if (c == exp_rsp) chk("rsp_rdata model", 32'(rsp_rdata), 32'(exp_rd));
            @(posedge CLK);
            #1;
        end
        HLDA = 1'b0;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [15:0] wd;
        int          h0;
        int          h1;
        logic [7:0]  din_lo;
        logic [7:0]  din_hi;
        int          exp_cyc;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t        vecs[6];
    int          rc, acc1, acc2, rsp1;
    logic [15:0] rd;
    logic        cs_at_acc, cs_after_acc, quiet;

    initial begin
        vecs[0] = '{2'd0, 4'hB, 16'h0058, 0, 0, 8'h00, 8'h00, 5, 16'h0000};
        vecs[1] = '{2'd2, 4'h2, 16'h1234, 0, 0, 8'h00, 8'h00, 1 + K16 * B, 16'h0000};
        vecs[2] = '{2'd3, 4'h1, 16'h0000, 0, 0, 8'hCD, 8'hAB, 1 + K16 * B, 16'hABCD};
        vecs[3] = '{2'd0, 4'h6, 16'h00A5, 10, 0, 8'h00, 8'h00, 15, 16'h0000};
        vecs[4] = '{2'd1, 4'h8, 16'h0000, 0, 0, 8'h5A, 8'h00, 5, 16'h005A};
        vecs[5] = '{2'd3, 4'h3, 16'hFFFF, 0, 2, 8'h01, 8'h80, 3 + K16 * B, 16'h8001};

        #2;
        chk("reset pins", 32'({req_ready, rsp_valid, CS_N, IOR_N, IOW_N, A, DB_OE, DB_OUT}),
            32'({1'b1, 1'b0, 3'b111, 4'h0, 1'b0, 8'h00}));
        chk("reset rsp_rdata", 32'(rsp_rdata), 32'h0);
        #10 RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].h0, vecs[i].h1, 0,
                    vecs[i].din_lo, vecs[i].din_hi, 1'b0, rc, rd);
            chk($sformatf("vec%0d rsp cycle", i), 32'(rc), 32'(vecs[i].exp_cyc));
            chk($sformatf("vec%0d rsp_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
        end

        for (int i = 0; i < 40; i++) begin
            run_req(2'($urandom), 4'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 8'($urandom),
                    8'($urandom), 1'b1, rc, rd);
        end

        // Reset during the strobe of a WRITE8.
        req_op = 2'd0; req_addr = 4'h4; req_wdata = 16'h0077; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        chk("pre-reset IOW_N", 32'(IOW_N), 32'h0);
        #2 RESET_N = 1'b0;
        #1;
        chk("async reset pins", 32'({CS_N, IOW_N, IOR_N, DB_OE, req_ready}), 32'h1D);
        @(negedge CLK);
        RESET_N = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (rsp_valid || !CS_N) quiet = 1'b0;
        end
        chk("no rsp after reset", 32'(quiet), 32'h1);
        chk("ready after reset", 32'(req_ready), 32'h1);
        @(posedge CLK); #1;

        // Back-to-back with req_valid held high.
        acc1 = -1; acc2 = -1; rsp1 = -1; cs_at_acc = 1'b0; cs_after_acc = 1'b1;
        req_op = 2'd0; req_addr = 4'h3; req_wdata = 16'h0011; req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (acc2 >= 0 && c == acc2 + 1) cs_after_acc = CS_N;
            if (req_valid && req_ready) begin
                if (acc1 < 0) acc1 = c;
                else if (acc2 < 0) begin
                    acc2 = c;
                    cs_at_acc = CS_N;
                end
            end
            if (rsp_valid && rsp1 < 0) rsp1 = c;
            @(posedge CLK); #1;
            if (c == acc1 && acc2 < 0) begin
                req_addr = 4'h5; req_wdata = 16'h0022;
            end
            if (c == acc2) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk("b2b first accept", 32'(acc1), 32'h0);
        chk("b2b first rsp", 32'(rsp1), 32'd5);
        chk("b2b second accept", 32'(acc2), 32'd6);
        chk("b2b CS_N at accept", 32'(cs_at_acc), 32'h1);
        chk("b2b CS_N after accept", 32'(cs_after_acc), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
